// File: rtl/prv32_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : prv32_mdu
//  Purpose  : Iterative RV32M multiply/divide unit with valid/ready request
//             and response handshakes. Multiplies by shift-add and divides by
//             restoring division, one bit per cycle over operand magnitudes.
//             Divide-by-zero, signed overflow and illegal ops can finish in
//             one cycle when EARLY_OUT=1.
//  Ports    : clk, rst (sync, active-high), flush (abort everything)
//             req_valid/req_ready/req_op/req_a/req_b/req_tag  - request side
//             rsp_valid/rsp_ready/rsp_result/rsp_tag          - response side
//             busy                                            - state != IDLE
//  Revision : 1.0  initial release
// ============================================================================
module prv32_mdu #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic [4:0]      req_tag,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic [4:0]      rsp_tag,
    output logic            busy
);

    localparam logic [4:0] c_OP_MUL    = 5'b00010;
    localparam logic [4:0] c_OP_MULH   = 5'b00110;
    localparam logic [4:0] c_OP_MULHU  = 5'b01011;
    localparam logic [4:0] c_OP_MULHSU = 5'b01100;
    localparam logic [4:0] c_OP_DIV    = 5'b01110;
    localparam logic [4:0] c_OP_DIVU   = 5'b10000;
    localparam logic [4:0] c_OP_REM    = 5'b10001;
    localparam logic [4:0] c_OP_REMU   = 5'b10010;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    logic [1:0]      r_state;
    logic [5:0]      r_cnt;
    // Shared datapath: for multiply {r_hi,r_lo} is the partial product with
    // the multiplier shifting out of r_lo; for divide r_hi is the partial
    // remainder and r_lo shifts the dividend out / quotient in.
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opnd;     // multiplicand or divisor magnitude
    logic            r_is_div;
    logic            r_sel_hi;   // MULH* upper word, or remainder for REM*
    logic            r_neg;      // product / quotient sign
    logic            r_rneg;     // remainder sign (dividend sign)
    logic            r_spec;     // special-case result overrides datapath
    logic [XLEN-1:0] r_spec_res;

    // ---------------- request decode ----------------
    logic            w_legal;
    logic            w_is_div;
    logic            w_sel_hi;
    logic            w_sgn_a;
    logic            w_sgn_b;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_ma;
    logic [XLEN-1:0] w_mb;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_res;

    always_comb begin
        w_legal  = 1'b1;
        w_is_div = 1'b0;
        w_sel_hi = 1'b0;
        w_sgn_a  = 1'b0;
        w_sgn_b  = 1'b0;
        case (req_op)
            c_OP_MUL:    begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            c_OP_MULH:   begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; w_sel_hi = 1'b1; end
            c_OP_MULHU:  begin w_sel_hi = 1'b1; end
            c_OP_MULHSU: begin w_sgn_a = 1'b1; w_sel_hi = 1'b1; end
            c_OP_DIV:    begin w_is_div = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            c_OP_DIVU:   begin w_is_div = 1'b1; end
            c_OP_REM:    begin w_is_div = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; w_sel_hi = 1'b1; end
            c_OP_REMU:   begin w_is_div = 1'b1; w_sel_hi = 1'b1; end
            default:     w_legal = 1'b0;
        endcase
    end

    assign w_sa = w_sgn_a & req_a[XLEN-1];
    assign w_sb = w_sgn_b & req_b[XLEN-1];
    assign w_ma = w_sa ? ('0 - req_a) : req_a;
    assign w_mb = w_sb ? ('0 - req_b) : req_b;

    assign w_div0    = w_is_div & (req_b == '0);
    assign w_ovf     = w_is_div & w_sgn_a & (req_a == {1'b1, {(XLEN-1){1'b0}}})
                     & (req_b == '1);
    assign w_special = ~w_legal | w_div0 | w_ovf;

    always_comb begin
        w_spec_res = '0;
        if (!w_legal)
            w_spec_res = '0;
        else if (w_div0)
            w_spec_res = w_sel_hi ? req_a : '1;
        else if (w_ovf)
            w_spec_res = w_sel_hi ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // ---------------- one iteration ----------------
    logic [XLEN:0]   w_add;
    logic [XLEN:0]   w_shift;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_hi_nx;
    logic [XLEN-1:0] w_lo_nx;

    assign w_add   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : '0)};
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    // A set carry-out bit means the shifted remainder already exceeds any
    // divisor, and the true difference still fits in XLEN bits.
    assign w_ge    = w_shift[XLEN] | (w_shift[XLEN-1:0] >= r_opnd);
    assign w_diff  = w_shift[XLEN-1:0] - r_opnd;

    assign w_hi_nx = r_is_div ? (w_ge ? w_diff : w_shift[XLEN-1:0]) : w_add[XLEN:1];
    assign w_lo_nx = r_is_div ? {r_lo[XLEN-2:0], w_ge} : {w_add[0], r_lo[XLEN-1:1]};

    // ---------------- sign fix-up of the final iteration ----------------
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign w_prod   = {w_hi_nx, w_lo_nx};
    assign w_prod_s = r_neg ? ('0 - w_prod) : w_prod;
    assign w_quo    = r_neg ? ('0 - w_lo_nx) : w_lo_nx;
    assign w_rem    = r_rneg ? ('0 - w_hi_nx) : w_hi_nx;

    always_comb begin
        w_final = '0;
        if (r_spec)
            w_final = r_spec_res;
        else if (r_is_div)
            w_final = r_sel_hi ? w_rem : w_quo;
        else
            w_final = r_sel_hi ? w_prod_s[2*XLEN-1:XLEN] : w_prod_s[XLEN-1:0];
    end

    assign req_ready = (r_state == c_ST_IDLE) & ~flush & ~rst;
    assign busy      = (r_state != c_ST_IDLE);

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_sel_hi   <= 1'b0;
            r_neg      <= 1'b0;
            r_rneg     <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_res <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_tag    <= '0;
        end else if (flush) begin
            r_state   <= c_ST_IDLE;
            rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_cnt      <= '0;
                        r_is_div   <= w_is_div;
                        r_sel_hi   <= w_sel_hi;
                        r_neg      <= w_sa ^ w_sb;
                        r_rneg     <= w_sa;
                        r_spec     <= w_special;
                        r_spec_res <= w_spec_res;
                        r_hi       <= '0;
                        r_lo       <= w_is_div ? w_ma : w_mb;
                        r_opnd     <= w_is_div ? w_mb : w_ma;
                        rsp_tag    <= req_tag;
                        if (EARLY_OUT && w_special) begin
                            r_state    <= c_ST_DONE;
                            rsp_valid  <= 1'b1;
                            rsp_result <= w_spec_res;
                        end else begin
                            r_state <= c_ST_CALC;
                        end
                    end
                end
                c_ST_CALC: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state    <= c_ST_DONE;
                        rsp_valid  <= 1'b1;
                        rsp_result <= w_final;
                    end
                end
                c_ST_DONE: begin
                    if (rsp_ready) begin
                        r_state   <= c_ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prv32_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prv32_mdu
//  Purpose  : Self-checking bench for prv32_mdu. Requests push the expected
//             result, tag and latency into a scoreboard; a monitor pops and
//             compares on each response handshake. A second instance with
//             EARLY_OUT=0 covers the full-latency special cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prv32_mdu;

    localparam logic [4:0] c_MUL    = 5'b00010;
    localparam logic [4:0] c_MULH   = 5'b00110;
    localparam logic [4:0] c_MULHU  = 5'b01011;
    localparam logic [4:0] c_MULHSU = 5'b01100;
    localparam logic [4:0] c_DIV    = 5'b01110;
    localparam logic [4:0] c_DIVU   = 5'b10000;
    localparam logic [4:0] c_REM    = 5'b10001;
    localparam logic [4:0] c_REMU   = 5'b10010;
    localparam logic [4:0] c_ILL    = 5'b00000;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, rsp_ready;
    logic [4:0]  req_op, req_tag;
    logic [31:0] req_a, req_b;
    logic        req_ready, rsp_valid, busy;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_tag;

    logic        req_valid2, req_ready2, rsp_valid2, busy2;
    logic [4:0]  req_op2, rsp_tag2;
    logic [31:0] req_a2, req_b2, rsp_result2;

    always #5 clk = ~clk;

    prv32_mdu #(.XLEN(32), .EARLY_OUT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag), .busy(busy)
    );

    prv32_mdu #(.XLEN(32), .EARLY_OUT(1'b0)) u_dut_noeo (
        .clk(clk), .rst(rst), .flush(1'b0),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_op(req_op2),
        .req_a(req_a2), .req_b(req_b2), .req_tag(5'd21),
        .rsp_valid(rsp_valid2), .rsp_ready(1'b1),
        .rsp_result(rsp_result2), .rsp_tag(rsp_tag2), .busy(busy2)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   last_acc = 0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                if (!seen) check("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
                seen = 1'b1;
            end else begin
                if (!seen) begin
                    check("latency", cyc - sb_q[0].acc, sb_q[0].lat);
                    seen = 1'b1;
                end
                if (rsp_ready) begin
                    check("result", rsp_result, sb_q[0].res);
                    check("tag", {27'b0, rsp_tag}, {27'b0, sb_q[0].tag});
                    void'(sb_q.pop_front());
                    seen = 1'b0;
                end
            end
        end else begin
            seen = 1'b0;
        end
    end

    // Called just after a rising edge; returns just after the edge that
    // follows the accept cycle.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] res, input int lat,
                         input bit push);
        int n;
        req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            check("accept_timeout", {31'b0, req_ready}, 32'd1);
        end else begin
            last_acc = cyc;
            if (push) sb_q.push_back('{res, tag, lat, cyc});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Later changes on the request bus must not disturb the captured op.
        req_op = 5'($urandom); req_a = $urandom; req_b = $urandom; req_tag = 5'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    // Kill an in-flight op at CALC iteration 10 via flush (use_rst=0) or rst.
    task automatic abort_test(input bit use_rst);
        int t;
        bit ok;
        issue(c_MUL, 32'h1234, 32'h5678, 5'd30, 32'd0, 0, 1'b0);
        t = last_acc;
        do begin @(posedge clk); #1; end while (cyc < t + 11);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        req_valid = 1'b1; req_op = c_DIVU; req_a = 32'd9; req_b = 32'd3;
        @(negedge clk);
        check(use_rst ? "rst_blocks_req" : "flush_blocks_req", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("abort_idle", {31'b0, busy}, 32'd0);
        if (use_rst) begin
            check("rst_result_clr", rsp_result, 32'd0);
            check("rst_tag_clr", {27'b0, rsp_tag}, 32'd0);
        end
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) ok = 1'b0;
        end
        check("no_rsp_after_abort", {31'b0, ok}, 32'd1);
        @(posedge clk); #1;
        issue(c_DIVU, 32'd100, 32'd7, use_rst ? 5'd18 : 5'd17, 32'd14, 33, 1'b1);
        drain();
    endtask

    vec_t vt[16];
    vec_t v2[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int t;
        int rel;
        bit ok_busy, ok_hold, ok_rdy;

        vt[0]  = '{c_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
        vt[1]  = '{c_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vt[2]  = '{c_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
        vt[3]  = '{c_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vt[4]  = '{c_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vt[5]  = '{c_DIVU,   32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33};
        vt[6]  = '{c_REMU,   32'd10,       32'd3,        32'd1,        33};
        vt[7]  = '{c_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vt[8]  = '{c_REMU,   32'd5,        32'd0,        32'd5,        1};
        vt[9]  = '{c_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vt[10] = '{c_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vt[11] = '{c_ILL,    32'd3,        32'd4,        32'd0,        1};
        vt[12] = '{c_MUL,    32'h12345678, 32'd9,        32'hA3D70A38, 33};
        vt[13] = '{c_MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
        vt[14] = '{c_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        vt[15] = '{c_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33};

        v2[0] = '{c_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 33};
        v2[1] = '{c_REMU, 32'd5,        32'd0,        32'd5,        33};
        v2[2] = '{c_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        v2[3] = '{c_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        33};
        v2[4] = '{c_ILL,  32'd3,        32'd4,        32'd0,        33};

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        req_valid2 = 1'b0; req_op2 = '0; req_a2 = '0; req_b2 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_tag", {27'b0, rsp_tag}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        // MUL with busy window T+1..T+33
        issue(c_MUL, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, 33, 1'b1);
        ok_busy = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) ok_busy = 1'b0;
        end
        check("busy_window", {31'b0, ok_busy}, 32'd1);
        @(negedge clk);
        check("busy_after_rsp", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 16; i++)
            issue(vt[i].op, vt[i].a, vt[i].b, 5'(i + 1), vt[i].res, vt[i].lat, 1'b1);
        drain();

        // Backpressure hold, then back-to-back accept
        rsp_ready = 1'b0;
        issue(c_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 33, 1'b1);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok_hold = 1'b1;
        ok_rdy  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd14 || rsp_tag !== 5'd9) ok_hold = 1'b0;
            if (req_ready !== 1'b0) ok_rdy = 1'b0;
        end
        check("hold_stable", {31'b0, ok_hold}, 32'd1);
        check("hold_no_accept", {31'b0, ok_rdy}, 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        rel = cyc;
        issue(c_MUL, 32'd3, 32'd4, 5'd10, 32'd12, 33, 1'b1);
        check("b2b_accept_cycle", last_acc, rel + 1);
        drain();

        // Abort mid-calculation
        abort_test(1'b0);
        abort_test(1'b1);

        // EARLY_OUT=0: special cases take the full latency
        for (int i = 0; i < 5; i++) begin
            req_op2 = v2[i].op; req_a2 = v2[i].a; req_b2 = v2[i].b; req_valid2 = 1'b1;
            n = 0;
            @(negedge clk);
            while (req_ready2 !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            t = cyc;
            @(posedge clk); #1;
            req_valid2 = 1'b0;
            n = 0;
            @(negedge clk);
            while (rsp_valid2 !== 1'b1 && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("noeo_latency", cyc - t, v2[i].lat);
            check("noeo_result", rsp_result2, v2[i].res);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
